alu_flag_wb: RTL and testbench
==============================

// Module: alu_flag_wb
// PURPOSE
//  Stage directly downstream of the ALU. Accepts the ALU result plus NZCV per instruction
//  and resolves the 4-bit condition code against the architectural flag register.
//  Updates flags when setFlags && pass, and buffers the result in a DEPTH-entry FIFO for
//  register-file writeback. Drives carryOut back to the ALU carry input.
// PARAMETERS
//  DATA_W  32  result width
//  REG_W   4   destination register index width
//  DEPTH   2   FIFO entries; power of two, 2..8
// PORTS
//  clk         in   1       single clock, rising edge
//  rst_n       in   1       asynchronous, active-low reset
//  inValid     in   1       upstream ALU result valid
//  inReady     out  1       stage can accept (= !full)
//  aluOut      in   DATA_W  ALU result
//  aluN/Z/C/V  in   1 each  ALU flags for this result
//  setFlags    in   1       instruction updates NZCV
//  regWrite    in   1       instruction writes the register file
//  destReg     in   REG_W   destination register
//  cond        in   4       condition code (ARM encoding)
//  outValid    out  1       FIFO head valid
//  outReady    in   1       register file consumes head
//  wbData      out  DATA_W  head result
//  wbReg       out  REG_W   head destination
//  wbEn        out  1       head write enable (regWrite && pass)
//  flagN/Z/C/V out  1 each  architectural flags
//  carryOut    out  1       = flagC, to ALU carry input
//  squashCount out  16      present only with COND_STATS_EN
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - FIFO empty, pointers/count 0, outValid=0.
//    - wbData=0, wbReg=0, wbEn=0; flags NZCV=0000, carryOut=0; inReady=1.
//    - In-flight entries are discarded. Mid-operation resets apply immediately.
//  - Accept: inValid && inReady at a rising edge.
//  - pass is combinational from cond and the current flag register:
//    - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
//    - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V
//    - C GT !Z&(N==V); D LE Z|(N!=V); E AL 1; F NV 0
//  - On accept:
//    - If setFlags && pass, the flag register loads aluN/Z/C/V at that edge.
//    - Otherwise the flag register holds.
//    - One entry {aluOut, destReg, regWrite&&pass} is pushed.
//    - A failed-condition instruction is still pushed (wbEn=0) to keep the ordering slot.
//  - Flags are updated in accept order, so instruction k+1 evaluates cond against the
//    flags left by instruction k. There is no bypass of same-cycle inputs.
//  - Latency: accepted entry appears at head (outValid=1) the cycle after accept when
//    FIFO was empty; no combinational in->out path.
//  - Pop: outValid && outReady at edge; head advances.
//  - Outputs when empty: outValid=0, and wbData/wbReg/wbEn are forced to 0.
//  - Full: inReady=0 even when a pop occurs the same cycle; no ready-through path.
//  - Push and pop in the same cycle with 0<count<DEPTH: count unchanged, sustaining
//    1 entry/cycle.
//  - Pointers wrap modulo DEPTH. Count is held in a log2(DEPTH)+1-bit counter.
//  - Upstream holds aluOut and the sideband signals stable while inValid && !inReady.
// CONFIGURATION
//  COND_STATS_EN defined:
//    - squashCount counts accepts with pass=0, +1 per accept.
//    - Saturates at 16'hFFFF; reset to 0.
//  COND_STATS_EN undefined:
//    - Port and counter are absent.
//    - All other behaviour is identical.
// TESTING
//  1 rst_n=0 while FIFO holds 2 entries -> immediately outValid=0, inReady=1, NZCV=0000,
//    carryOut=0, wbEn=0.
//  2 Instruction A: aluOut=0, Z=1, C=1, setFlags=1, cond=E -> NZCV=0110, carryOut=1.
//    Then B with cond=0 regWrite=1 -> wbEn=1; C with cond=1 -> wbEn=0, wbData still
//    delivered.
//  3 outReady=0, present 3 results 0x11,0x22,0x33:
//    - inReady=0 after the 2nd accept.
//    - Release outReady -> pops 0x11,0x22,0x33 in order; the 3rd is accepted only once
//      not full.
//  4 cond=F with setFlags=1 and aluN=1 -> flags unchanged, entry wbEn=0.
//    cond=A with N=1,V=0 -> fails.
//  5 Eight back-to-back accepts with outReady=1 -> eight pops on consecutive cycles
//    after 1-cycle latency; count never exceeds 1.
//  6 COND_STATS_EN: 3 failed conds -> squashCount=3.
//    Preload 16'hFFFE then 3 fails -> 16'hFFFF.

Source files
------------

// File: rtl/alu_flag_wb.sv
// alu_flag_wb: post-ALU stage. Resolves the ARM condition code against the
// architectural NZCV register, conditionally updates the flags and queues
// results in a DEPTH-entry FIFO for register-file writeback.
// Optional feature macro: COND_STATS_EN (adds squashCount failed-condition counter).
module alu_flag_wb #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [DATA_W-1:0] aluOut,
  input  logic              aluN,
  input  logic              aluZ,
  input  logic              aluC,
  input  logic              aluV,
  input  logic              setFlags,
  input  logic              regWrite,
  input  logic [REG_W-1:0]  destReg,
  input  logic [3:0]        cond,
  output logic              outValid,
  input  logic              outReady,
  output logic [DATA_W-1:0] wbData,
  output logic [REG_W-1:0]  wbReg,
  output logic              wbEn,
  output logic              flagN,
  output logic              flagZ,
  output logic              flagC,
  output logic              flagV,
  output logic              carryOut
`ifdef COND_STATS_EN
  ,
  output logic [15:0]       squashCount
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [REG_W-1:0]  r_reg  [DEPTH];
  logic [DEPTH-1:0]  r_en;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_n;
  logic              r_z;
  logic              r_c;
  logic              r_v;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_pass;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = inValid && !w_full;
  assign w_pop   = !w_empty && outReady;

  // Condition evaluation against the current architectural flags
  always_comb begin
    w_pass = 1'b0;
    unique case (cond)
      4'h0: w_pass = r_z;
      4'h1: w_pass = !r_z;
      4'h2: w_pass = r_c;
      4'h3: w_pass = !r_c;
      4'h4: w_pass = r_n;
      4'h5: w_pass = !r_n;
      4'h6: w_pass = r_v;
      4'h7: w_pass = !r_v;
      4'h8: w_pass = r_c && !r_z;
      4'h9: w_pass = !r_c || r_z;
      4'hA: w_pass = (r_n == r_v);
      4'hB: w_pass = (r_n != r_v);
      4'hC: w_pass = !r_z && (r_n == r_v);
      4'hD: w_pass = r_z || (r_n != r_v);
      4'hE: w_pass = 1'b1;
      4'hF: w_pass = 1'b0;
      default: w_pass = 1'b0;
    endcase
  end

  // Architectural flag register, updated in accept order
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n <= 1'b0;
      r_z <= 1'b0;
      r_c <= 1'b0;
      r_v <= 1'b0;
    end else if (w_push && setFlags && w_pass) begin
      r_n <= aluN;
      r_z <= aluZ;
      r_c <= aluC;
      r_v <= aluV;
    end
  end

  // FIFO storage and write pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_data[i] <= '0;
        r_reg[i]  <= '0;
      end
      r_en     <= '0;
      r_wr_ptr <= '0;
    end else if (w_push) begin
      r_data[r_wr_ptr] <= aluOut;
      r_reg[r_wr_ptr]  <= destReg;
      r_en[r_wr_ptr]   <= regWrite && w_pass;
      r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
    end
  end

  // Read pointer and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef COND_STATS_EN
  logic [15:0] r_squash_cnt;

  // Saturating count of accepted instructions whose condition failed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_squash_cnt <= '0;
    end else if (w_push && !w_pass && (r_squash_cnt != 16'hFFFF)) begin
      r_squash_cnt <= r_squash_cnt + 16'd1;
    end
  end

  assign squashCount = r_squash_cnt;
`endif

  // Head outputs come straight from storage; zeroed when the FIFO is empty
  assign inReady  = !w_full;
  assign outValid = !w_empty;
  assign wbData   = w_empty ? '0 : r_data[r_rd_ptr];
  assign wbReg    = w_empty ? '0 : r_reg[r_rd_ptr];
  assign wbEn     = w_empty ? 1'b0 : r_en[r_rd_ptr];
  assign flagN    = r_n;
  assign flagZ    = r_z;
  assign flagC    = r_c;
  assign flagV    = r_v;
  assign carryOut = r_c;

endmodule

// File: tb/tb_alu_flag_wb.sv
// Self-checking bench for alu_flag_wb: directed scenarios followed by
// random traffic, all checked against a queue-based reference model.
module tb_alu_flag_wb;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 4;
  localparam int unsigned DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              inValid;
  logic              inReady;
  logic [DATA_W-1:0] aluOut;
  logic              aluN, aluZ, aluC, aluV;
  logic              setFlags;
  logic              regWrite;
  logic [REG_W-1:0]  destReg;
  logic [3:0]        cond;
  logic              outValid;
  logic              outReady;
  logic [DATA_W-1:0] wbData;
  logic [REG_W-1:0]  wbReg;
  logic              wbEn;
  logic              flagN, flagZ, flagC, flagV;
  logic              carryOut;
`ifdef COND_STATS_EN
  logic [15:0]       squashCount;
`endif

  alu_flag_wb #(.DATA_W(DATA_W), .REG_W(REG_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .inValid(inValid), .inReady(inReady),
    .aluOut(aluOut), .aluN(aluN), .aluZ(aluZ), .aluC(aluC), .aluV(aluV),
    .setFlags(setFlags), .regWrite(regWrite), .destReg(destReg), .cond(cond),
    .outValid(outValid), .outReady(outReady),
    .wbData(wbData), .wbReg(wbReg), .wbEn(wbEn),
    .flagN(flagN), .flagZ(flagZ), .flagC(flagC), .flagV(flagV),
    .carryOut(carryOut)
`ifdef COND_STATS_EN
    , .squashCount(squashCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [REG_W-1:0]  r;
    logic              e;
  } ent_t;

  ent_t     q[$];
  logic [3:0] mflags;   // {N,Z,C,V}
  int       msquash;
  int       n_checks = 0;
  int       n_pass   = 0;

  // Condition as "base predicate of the pair, inverted by the low bit"
  function automatic logic ref_pass(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v, base;
    {n, z, c, v} = f;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    ent_t h;
    h = (q.size() > 0) ? q[0] : '0;
    chk({tag, ":outValid"}, 32'(outValid), 32'(q.size() > 0));
    chk({tag, ":inReady"},  32'(inReady),  32'(q.size() < DEPTH));
    chk({tag, ":wbData"},   32'(wbData),   32'(h.d));
    chk({tag, ":wbReg"},    32'(wbReg),    32'(h.r));
    chk({tag, ":wbEn"},     32'(wbEn),     32'(h.e));
    chk({tag, ":NZCV"},     32'({flagN, flagZ, flagC, flagV}), 32'(mflags));
    chk({tag, ":carryOut"}, 32'(carryOut), 32'(mflags[1]));
`ifdef COND_STATS_EN
    chk({tag, ":squash"},   32'(squashCount), 32'(msquash));
`endif
  endtask

  // One clock: drive inputs, predict from pre-edge model state, check after edge
  task automatic cyc(input string tag, input logic iv, input logic [DATA_W-1:0] d,
                     input logic [3:0] nzcv, input logic sf, input logic rw,
                     input logic [REG_W-1:0] dr, input logic [3:0] cc, input logic ordy);
    logic acc, pop, p;
    ent_t tmp;
    inValid = iv; aluOut = d; {aluN, aluZ, aluC, aluV} = nzcv;
    setFlags = sf; regWrite = rw; destReg = dr; cond = cc; outReady = ordy;
    acc = iv && (q.size() < DEPTH);
    pop = ordy && (q.size() > 0);
    @(posedge clk);
    #1;
    if (pop) tmp = q.pop_front();
    if (acc) begin
      p = ref_pass(cc, mflags);
      q.push_back('{d: d, r: dr, e: rw && p});
      if (sf && p) mflags = nzcv;
      if (!p && msquash < 16'hFFFF) msquash++;
    end
    check_all(tag);
  endtask

  task automatic model_reset();
    q.delete();
    mflags  = 4'b0000;
    msquash = 0;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [3:0]        rf, rc;
    logic              rs, rw, riv;
    logic [REG_W-1:0]  rr;
    logic              hold;

    rst_n = 1'b0;
    inValid = 1'b0; aluOut = '0; {aluN, aluZ, aluC, aluV} = 4'b0;
    setFlags = 1'b0; regWrite = 1'b0; destReg = '0; cond = 4'h0; outReady = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Mid-operation reset with two buffered entries
    cyc("fill0", 1'b1, 32'hAAAA0001, 4'b1111, 1'b1, 1'b1, 4'd1, 4'hE, 1'b0);
    cyc("fill1", 1'b1, 32'hAAAA0002, 4'b0000, 1'b0, 1'b1, 4'd2, 4'hE, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    inValid = 1'b0;

    // A sets Z and C; B (EQ) writes; C (NE) squashed but delivered
    cyc("instA", 1'b1, 32'h0,        4'b0110, 1'b1, 1'b0, 4'd0, 4'hE, 1'b1);
    cyc("instB", 1'b1, 32'h12345678, 4'b0000, 1'b0, 1'b1, 4'd3, 4'h0, 1'b1);
    cyc("instC", 1'b1, 32'h9ABCDEF0, 4'b0000, 1'b0, 1'b1, 4'd4, 4'h1, 1'b1);
    cyc("drainC", 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1);

    // Backpressure: fill, hold third while full, then drain in order
    cyc("bp11", 1'b1, 32'h11, 4'b0000, 1'b0, 1'b1, 4'd5, 4'hE, 1'b0);
    cyc("bp22", 1'b1, 32'h22, 4'b0000, 1'b0, 1'b1, 4'd6, 4'hE, 1'b0);
    cyc("bp33a", 1'b1, 32'h33, 4'b0000, 1'b0, 1'b1, 4'd7, 4'hE, 1'b0);
    cyc("bp33b", 1'b1, 32'h33, 4'b0000, 1'b0, 1'b1, 4'd7, 4'hE, 1'b1);
    cyc("bp33c", 1'b1, 32'h33, 4'b0000, 1'b0, 1'b1, 4'd7, 4'hE, 1'b1);
    repeat (3) cyc("bpdrain", 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1);

    // NV never passes; GE fails with N=1,V=0
    cyc("nv", 1'b1, 32'h44, 4'b1000, 1'b1, 1'b1, 4'd8, 4'hF, 1'b1);
    cyc("setN", 1'b1, 32'h55, 4'b1000, 1'b1, 1'b0, 4'd9, 4'hE, 1'b1);
    cyc("ge", 1'b1, 32'h66, 4'b0000, 1'b0, 1'b1, 4'd10, 4'hA, 1'b1);
    cyc("lt", 1'b1, 32'h77, 4'b0000, 1'b0, 1'b1, 4'd11, 4'hB, 1'b1);

    // Eight back-to-back accepts with the sink always ready
    for (int i = 0; i < 8; i++)
      cyc("stream", 1'b1, 32'(32'h100 + i), 4'(i), 1'b1, 1'b1, 4'(i), 4'(i * 2), 1'b1);
    cyc("stream_end", 1'b0, 32'h0, 4'b0000, 1'b0, 1'b0, 4'd0, 4'h0, 1'b1);

    // Random traffic; inputs held while stalled
    hold = 1'b0;
    rd = '0; rf = '0; rs = 1'b0; rw = 1'b0; rr = '0; rc = '0; riv = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        riv = 1'($urandom_range(0, 3) != 0);
        rd  = $urandom;
        rf  = 4'($urandom);
        rs  = 1'($urandom);
        rw  = 1'($urandom);
        rr  = REG_W'($urandom);
        rc  = 4'($urandom);
      end
      hold = riv && (q.size() >= DEPTH);
      cyc("rand", riv, rd, rf, rs, rw, rr, rc, 1'($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
